// File: rtl/decode_stage.sv
// Decode stage of a five-stage pipeline: register file with write-through,
// load-use and branch-operand hazard detection, early branch resolution,
// exception return address capture and the ID/EX pipeline register.
module decode_stage #(
  parameter int DATA_W  = 32,
  parameter int NREG    = 32,
  parameter int CTRL_W  = 16,
  parameter int EPC_REG = 26,
  localparam int AW     = $clog2(NREG)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc_plus4,
  input  logic [AW-1:0]     id_rs,
  input  logic [AW-1:0]     id_rt,
  input  logic              id_rs_used,
  input  logic              id_rt_used,
  input  logic [2:0]        id_br_op,
  input  logic [AW-1:0]     id_dst,
  input  logic              id_mem_read,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              exc_req,
  input  logic              mem_valid,
  input  logic              mem_mem_read,
  input  logic [AW-1:0]     mem_dst,
  input  logic              wb_we,
  input  logic [AW-1:0]     wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              ex_flush,
  output logic              pc_write,
  output logic              br_taken,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic [AW-1:0]     ex_dst,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [DATA_W-1:0] ex_rs_data,
  output logic [DATA_W-1:0] ex_rt_data,
  output logic [DATA_W-1:0] ex_pc_plus4,
  output logic [15:0]       stall_count
);

  localparam logic [AW-1:0] EPC_IDX = AW'(EPC_REG);

  typedef enum logic [2:0] {
    BR_NONE = 3'b000,
    BR_BEQ  = 3'b001,
    BR_BNE  = 3'b010,
    BR_BLEZ = 3'b011,
    BR_BGTZ = 3'b100,
    BR_BGEZ = 3'b101,
    BR_BLTZ = 3'b110,
    BR_RSVD = 3'b111
  } br_op_e;

  logic [DATA_W-1:0] regs_q [NREG];
  logic [DATA_W-1:0] rs_data, rt_data;

  logic              ex_valid_q, ex_valid_d;
  logic              ex_mem_read_q, ex_mem_read_d;
  logic [AW-1:0]     ex_dst_q, ex_dst_d;
  logic [CTRL_W-1:0] ex_ctrl_q, ex_ctrl_d;
  logic [DATA_W-1:0] ex_rs_data_q, ex_rs_data_d;
  logic [DATA_W-1:0] ex_rt_data_q, ex_rt_data_d;
  logic [DATA_W-1:0] ex_pc_plus4_q, ex_pc_plus4_d;
  logic [15:0]       stall_count_q, stall_count_d;

  logic rs_ex, rt_ex, rs_mem, rt_mem, mem_load;
  logic load_use, br_hazard, stall, bubble;
  logic epc_we;
  logic [DATA_W-1:0] epc_val;
  logic rs_neg, rs_zero, br_cond;

  // Source operand read with write-through of a same-cycle writeback; r0 is hardwired zero.
  always_comb begin
    rs_data = '0;
    rt_data = '0;
    if (id_rs != '0) begin
      if (wb_we && (wb_addr == id_rs)) rs_data = wb_data;
      else                             rs_data = regs_q[id_rs];
    end
    if (id_rt != '0) begin
      if (wb_we && (wb_addr == id_rt)) rt_data = wb_data;
      else                             rt_data = regs_q[id_rt];
    end
  end

  // The exception return address only lands when the excepting instruction is not squashed.
  assign epc_we  = exc_req & id_valid & ~ex_flush;
  assign epc_val = id_pc_plus4 - DATA_W'(4);

  // Register file write: writeback first, exception capture overrides on the same index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
    end else begin
      if (wb_we && (wb_addr != '0)) regs_q[wb_addr] <= wb_data;
      if (epc_we && (EPC_IDX != '0)) regs_q[EPC_IDX] <= epc_val;
    end
  end

  // Hazard detection against the EX-stage producer and a load still in MEM.
  always_comb begin
    rs_ex     = id_rs_used & (id_rs == ex_dst_q);
    rt_ex     = id_rt_used & (id_rt == ex_dst_q);
    rs_mem    = id_rs_used & (id_rs == mem_dst);
    rt_mem    = id_rt_used & (id_rt == mem_dst);
    mem_load  = mem_valid & mem_mem_read & (mem_dst != '0);
    load_use  = id_valid & ex_valid_q & ex_mem_read_q & (ex_dst_q != '0) & (rs_ex | rt_ex);
    br_hazard = id_valid & (id_br_op != BR_NONE) &
                ((ex_valid_q & (ex_dst_q != '0) & (rs_ex | rt_ex)) |
                 (mem_load & (rs_mem | rt_mem)));
    stall     = load_use | br_hazard;
  end

  assign pc_write = ~stall;

  // Branch condition on the bypassed operands, rs treated as signed.
  always_comb begin
    rs_neg  = rs_data[DATA_W-1];
    rs_zero = (rs_data == '0);
    br_cond = 1'b0;
    case (br_op_e'(id_br_op))
      BR_BEQ:  br_cond = (rs_data == rt_data);
      BR_BNE:  br_cond = (rs_data != rt_data);
      BR_BLEZ: br_cond = rs_neg | rs_zero;
      BR_BGTZ: br_cond = ~rs_neg & ~rs_zero;
      BR_BGEZ: br_cond = ~rs_neg;
      BR_BLTZ: br_cond = rs_neg;
      default: br_cond = 1'b0;
    endcase
  end

  assign br_taken = id_valid & ~stall & br_cond;

  // ID/EX next value: a fully zeroed bubble unless a real, unstalled, unsquashed instruction is in decode.
  always_comb begin
    bubble        = ex_flush | exc_req | stall | ~id_valid;
    ex_valid_d    = 1'b0;
    ex_mem_read_d = 1'b0;
    ex_dst_d      = '0;
    ex_ctrl_d     = '0;
    ex_rs_data_d  = '0;
    ex_rt_data_d  = '0;
    ex_pc_plus4_d = '0;
    if (!bubble) begin
      ex_valid_d    = 1'b1;
      ex_mem_read_d = id_mem_read;
      ex_dst_d      = id_dst;
      ex_ctrl_d     = id_ctrl;
      ex_rs_data_d  = rs_data;
      ex_rt_data_d  = rt_data;
      ex_pc_plus4_d = id_pc_plus4;
    end
  end

  // Stall cycles are counted only when decode is not being squashed; the counter sticks at all-ones.
  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && !ex_flush && (stall_count_q != 16'hFFFF)) stall_count_d = stall_count_q + 16'd1;
  end

  // ID/EX pipeline register and stall counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_q    <= 1'b0;
      ex_mem_read_q <= 1'b0;
      ex_dst_q      <= '0;
      ex_ctrl_q     <= '0;
      ex_rs_data_q  <= '0;
      ex_rt_data_q  <= '0;
      ex_pc_plus4_q <= '0;
      stall_count_q <= '0;
    end else begin
      ex_valid_q    <= ex_valid_d;
      ex_mem_read_q <= ex_mem_read_d;
      ex_dst_q      <= ex_dst_d;
      ex_ctrl_q     <= ex_ctrl_d;
      ex_rs_data_q  <= ex_rs_data_d;
      ex_rt_data_q  <= ex_rt_data_d;
      ex_pc_plus4_q <= ex_pc_plus4_d;
      stall_count_q <= stall_count_d;
    end
  end

  assign ex_valid    = ex_valid_q;
  assign ex_mem_read = ex_mem_read_q;
  assign ex_dst      = ex_dst_q;
  assign ex_ctrl     = ex_ctrl_q;
  assign ex_rs_data  = ex_rs_data_q;
  assign ex_rt_data  = ex_rt_data_q;
  assign ex_pc_plus4 = ex_pc_plus4_q;
  assign stall_count = stall_count_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: register file, hazards, branches, exceptions, counter, reset.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic        id_valid;
  logic [31:0] id_pc_plus4;
  logic [4:0]  id_rs, id_rt;
  logic        id_rs_used, id_rt_used;
  logic [2:0]  id_br_op;
  logic [4:0]  id_dst;
  logic        id_mem_read;
  logic [15:0] id_ctrl;
  logic        exc_req;
  logic        mem_valid, mem_mem_read;
  logic [4:0]  mem_dst;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        ex_flush;
  logic        pc_write, br_taken, ex_valid, ex_mem_read;
  logic [4:0]  ex_dst;
  logic [15:0] ex_ctrl;
  logic [31:0] ex_rs_data, ex_rt_data, ex_pc_plus4;
  logic [15:0] stall_count;

  int checks = 0;
  int errors = 0;

  decode_stage dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc_plus4(id_pc_plus4),
    .id_rs(id_rs), .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
    .id_br_op(id_br_op), .id_dst(id_dst), .id_mem_read(id_mem_read), .id_ctrl(id_ctrl),
    .exc_req(exc_req), .mem_valid(mem_valid), .mem_mem_read(mem_mem_read), .mem_dst(mem_dst),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .ex_flush(ex_flush),
    .pc_write(pc_write), .br_taken(br_taken), .ex_valid(ex_valid), .ex_mem_read(ex_mem_read),
    .ex_dst(ex_dst), .ex_ctrl(ex_ctrl), .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data),
    .ex_pc_plus4(ex_pc_plus4), .stall_count(stall_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    id_valid = 1'b0; id_pc_plus4 = 32'd0; id_rs = 5'd0; id_rt = 5'd0;
    id_rs_used = 1'b0; id_rt_used = 1'b0; id_br_op = 3'd0; id_dst = 5'd0;
    id_mem_read = 1'b0; id_ctrl = 16'd0; exc_req = 1'b0; ex_flush = 1'b0;
    mem_valid = 1'b0; mem_mem_read = 1'b0; mem_dst = 5'd0;
    wb_we = 1'b0; wb_addr = 5'd0; wb_data = 32'd0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    clr();
    wb_we = 1'b1; wb_addr = a; wb_data = d;
    tick();
    wb_we = 1'b0;
  endtask

  task automatic br(input string tag, input logic [2:0] op, input logic [4:0] rs,
                    input logic [4:0] rt, input logic exp);
    clr();
    id_valid = 1'b1; id_br_op = op; id_rs = rs; id_rt = rt;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
    #1;
    chk(tag, 64'(br_taken), 64'(exp));
    tick();
  endtask

  task automatic rd26(input string tag, input logic [31:0] exp);
    clr();
    id_valid = 1'b1; id_rs = 5'd26; id_rs_used = 1'b1;
    tick();
    chk(tag, 64'(ex_rs_data), 64'(exp));
  endtask

  task automatic mem_branch_r3();
    clr();
    mem_valid = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd3;
    id_valid = 1'b1; id_br_op = 3'b001; id_rs = 5'd3; id_rt = 5'd3;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
  endtask

  initial begin
    // reset state
    clr();
    rst_n = 1'b0;
    #2;
    chk("rst_ex_valid", 64'(ex_valid), 64'd0);
    chk("rst_ex_dst", 64'(ex_dst), 64'd0);
    chk("rst_ex_rs_data", 64'(ex_rs_data), 64'd0);
    chk("rst_stall_count", 64'(stall_count), 64'd0);
    chk("rst_pc_write", 64'(pc_write), 64'd1);
    #1 rst_n = 1'b1;
    tick();

    // write-through of r5 into a same-cycle read
    clr();
    wb_we = 1'b1; wb_addr = 5'd5; wb_data = 32'h0000_1234;
    id_valid = 1'b1; id_rs = 5'd5; id_rs_used = 1'b1; id_dst = 5'd9;
    id_ctrl = 16'hA5A5; id_pc_plus4 = 32'h0000_0100;
    tick();
    chk("bypass_rs", 64'(ex_rs_data), 64'h1234);
    chk("pass_valid", 64'(ex_valid), 64'd1);
    chk("pass_dst", 64'(ex_dst), 64'd9);
    chk("pass_ctrl", 64'(ex_ctrl), 64'hA5A5);
    chk("pass_pc4", 64'(ex_pc_plus4), 64'h100);
    chk("pass_mem_read", 64'(ex_mem_read), 64'd0);

    // r0 reads zero even with a write aimed at it; r5 retained
    clr();
    wb_we = 1'b1; wb_addr = 5'd0; wb_data = 32'hDEAD_BEEF;
    id_valid = 1'b1; id_rt = 5'd5; id_rt_used = 1'b1;
    tick();
    chk("r0_zero", 64'(ex_rs_data), 64'd0);
    chk("r5_stored", 64'(ex_rt_data), 64'h1234);

    wr(5'd1, 32'd7);
    wr(5'd2, 32'd7);
    wr(5'd3, 32'd5);
    wr(5'd6, 32'h8000_0000);

    // invalid decode produces an all-zero bubble
    clr();
    id_ctrl = 16'hFFFF; id_dst = 5'd7; id_mem_read = 1'b1; id_pc_plus4 = 32'h44;
    tick();
    chk("bubble_valid", 64'(ex_valid), 64'd0);
    chk("bubble_ctrl", 64'(ex_ctrl), 64'd0);
    chk("bubble_dst", 64'(ex_dst), 64'd0);
    chk("bubble_pc4", 64'(ex_pc_plus4), 64'd0);

    // load-use on r8
    clr();
    id_valid = 1'b1; id_mem_read = 1'b1; id_dst = 5'd8;
    tick();
    chk("lw_in_ex", 64'(ex_mem_read), 64'd1);
    clr();
    id_valid = 1'b1; id_rs = 5'd8; id_rs_used = 1'b1; id_rt = 5'd2; id_rt_used = 1'b1;
    id_dst = 5'd10; id_ctrl = 16'h0042; id_pc_plus4 = 32'h200;
    #1;
    chk("lu_pc_write", 64'(pc_write), 64'd0);
    tick();
    chk("lu_bubble", 64'(ex_valid), 64'd0);
    chk("lu_count", 64'(stall_count), 64'd1);
    chk("lu_release_pc", 64'(pc_write), 64'd1);
    tick();
    chk("lu_issue_valid", 64'(ex_valid), 64'd1);
    chk("lu_issue_dst", 64'(ex_dst), 64'd10);
    chk("lu_issue_rt", 64'(ex_rt_data), 64'd7);

    // unused source does not create a load-use stall
    clr();
    id_valid = 1'b1; id_mem_read = 1'b1; id_dst = 5'd8;
    tick();
    clr();
    id_valid = 1'b1; id_rs = 5'd8; id_rs_used = 1'b0; id_dst = 5'd11;
    #1;
    chk("unused_pc_write", 64'(pc_write), 64'd1);
    tick();
    chk("unused_valid", 64'(ex_valid), 64'd1);
    chk("unused_count", 64'(stall_count), 64'd1);

    // branch conditions (r1=7 r2=7 r3=5 r6=0x80000000)
    br("beq_eq", 3'b001, 5'd1, 5'd2, 1'b1);
    clr();
    id_valid = 1'b1; id_br_op = 3'b001; id_rs = 5'd1; id_rt = 5'd2;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
    wb_we = 1'b1; wb_addr = 5'd2; wb_data = 32'd8;
    #1;
    chk("beq_bypass_ne", 64'(br_taken), 64'd0);
    tick();
    br("bne_ne", 3'b010, 5'd1, 5'd2, 1'b1);
    br("bltz_min", 3'b110, 5'd6, 5'd0, 1'b1);
    br("blez_zero", 3'b011, 5'd0, 5'd0, 1'b1);
    br("bgtz_zero", 3'b100, 5'd0, 5'd0, 1'b0);
    br("bgez_neg", 3'b101, 5'd6, 5'd0, 1'b0);
    br("bgtz_pos", 3'b100, 5'd1, 5'd0, 1'b1);
    br("blez_neg", 3'b011, 5'd6, 5'd0, 1'b1);
    br("reserved", 3'b111, 5'd1, 5'd1, 1'b0);
    clr();
    id_valid = 1'b0; id_br_op = 3'b001; id_rs = 5'd1; id_rt = 5'd1;
    #1;
    chk("br_invalid", 64'(br_taken), 64'd0);
    tick();

    // branch on r3 while MEM holds a load to r3
    clr();
    mem_valid = 1'b1; mem_mem_read = 1'b1; mem_dst = 5'd3;
    id_valid = 1'b1; id_br_op = 3'b010; id_rs = 5'd3; id_rt = 5'd1;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
    #1;
    chk("memhz_pc_write", 64'(pc_write), 64'd0);
    chk("memhz_br_taken", 64'(br_taken), 64'd0);
    tick();
    chk("memhz_bubble", 64'(ex_valid), 64'd0);
    chk("memhz_count", 64'(stall_count), 64'd2);
    mem_valid = 1'b0;
    #1;
    chk("memhz_resolve_pc", 64'(pc_write), 64'd1);
    chk("memhz_resolve_br", 64'(br_taken), 64'd1);
    tick();
    chk("memhz_issue", 64'(ex_valid), 64'd1);

    // MEM non-load to r3 is not a hazard
    mem_valid = 1'b1; mem_mem_read = 1'b0; mem_dst = 5'd3;
    #1;
    chk("mem_nonload", 64'(pc_write), 64'd1);
    tick();

    // branch on r3 while EX holds an ALU result for r3
    clr();
    id_valid = 1'b1; id_dst = 5'd3;
    tick();
    clr();
    id_valid = 1'b1; id_br_op = 3'b001; id_rs = 5'd3; id_rt = 5'd3;
    id_rs_used = 1'b1; id_rt_used = 1'b1;
    #1;
    chk("exhz_pc_write", 64'(pc_write), 64'd0);
    chk("exhz_br_taken", 64'(br_taken), 64'd0);
    tick();
    chk("exhz_count", 64'(stall_count), 64'd3);
    chk("exhz_resolve_br", 64'(br_taken), 64'd1);
    tick();

    // flush during a stall does not count; flush squashes a good instruction
    mem_branch_r3();
    ex_flush = 1'b1;
    #1;
    chk("flush_stall_pc", 64'(pc_write), 64'd0);
    tick();
    chk("flush_count_hold", 64'(stall_count), 64'd3);
    chk("flush_stall_bubble", 64'(ex_valid), 64'd0);
    clr();
    id_valid = 1'b1; id_dst = 5'd5; ex_flush = 1'b1;
    tick();
    chk("flush_squash", 64'(ex_valid), 64'd0);

    // exception capture beats same-cycle writeback to r26
    clr();
    id_valid = 1'b1; exc_req = 1'b1; id_pc_plus4 = 32'h0040_0010; id_dst = 5'd4; id_ctrl = 16'h0001;
    wb_we = 1'b1; wb_addr = 5'd26; wb_data = 32'h0000_00FF;
    #1;
    chk("exc_no_stall", 64'(pc_write), 64'd1);
    tick();
    chk("exc_bubble", 64'(ex_valid), 64'd0);
    rd26("epc_value", 32'h0040_000C);
    clr();
    id_valid = 1'b1; exc_req = 1'b1; id_pc_plus4 = 32'h0000_0002;
    tick();
    rd26("epc_wrap", 32'hFFFF_FFFE);
    clr();
    id_valid = 1'b1; exc_req = 1'b1; ex_flush = 1'b1; id_pc_plus4 = 32'h0050_0010;
    tick();
    rd26("epc_flush_ignored", 32'hFFFF_FFFE);
    clr();
    id_valid = 1'b0; exc_req = 1'b1; id_pc_plus4 = 32'h0060_0010;
    tick();
    rd26("epc_invalid_ignored", 32'hFFFF_FFFE);

    // long stall saturates the counter
    mem_branch_r3();
    repeat (70000) @(posedge clk);
    #1;
    chk("sat_count", 64'(stall_count), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(stall_count), 64'hFFFF);

    // asynchronous reset in the middle of a stall
    clr();
    id_valid = 1'b1; id_dst = 5'd9; id_ctrl = 16'h1357; id_pc_plus4 = 32'h300;
    id_rs = 5'd1; id_rs_used = 1'b1;
    tick();
    chk("pre_rst_valid", 64'(ex_valid), 64'd1);
    mem_branch_r3();
    #1;
    chk("pre_rst_stall", 64'(pc_write), 64'd0);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", 64'(ex_valid), 64'd0);
    chk("arst_ctrl", 64'(ex_ctrl), 64'd0);
    chk("arst_dst", 64'(ex_dst), 64'd0);
    chk("arst_pc4", 64'(ex_pc_plus4), 64'd0);
    chk("arst_rs_data", 64'(ex_rs_data), 64'd0);
    chk("arst_count", 64'(stall_count), 64'd0);
    chk("arst_pc_write", 64'(pc_write), 64'd0);
    rst_n = 1'b1;
    #1;
    chk("release_count", 64'(stall_count), 64'd0);
    chk("release_valid", 64'(ex_valid), 64'd0);
    tick();
    chk("first_edge_valid", 64'(ex_valid), 64'd0);
    clr();
    id_valid = 1'b1; id_rs = 5'd1; id_rs_used = 1'b1; id_rt = 5'd26; id_rt_used = 1'b1;
    tick();
    chk("rf_cleared_r1", 64'(ex_rs_data), 64'd0);
    chk("rf_cleared_r26", 64'(ex_rt_data), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, datapath width.
REQ-002 SHALL have parameter NREG, default 32, register count (power of 2, >=4); AW = log2(NREG).
REQ-003 SHALL have parameter CTRL_W, default 16, opaque control bundle width.
REQ-004 SHALL have parameter EPC_REG, default 26, register receiving exception return address.
REQ-005 SHALL have ports, one per line:
  clk  in  1  clock; one clock domain
  rst_n  in  1  reset, asynchronous, active-low
  id_valid  in  1  instruction in decode is real
  id_pc_plus4  in  DATA_W  PC+4 of decode instruction
  id_rs, id_rt  in  AW  source indexes
  id_rs_used, id_rt_used  in  1  source actually read
  id_br_op  in  3  000 none, 001 beq, 010 bne, 011 blez, 100 bgtz, 101 bgez, 110 bltz, 111 reserved
  id_dst  in  AW  destination index
  id_mem_read  in  1  instruction is a load
  id_ctrl  in  CTRL_W  control bundle passed to EX
  exc_req  in  1  take exception on decode instruction
  mem_valid, mem_mem_read  in  1  load state of MEM stage
  mem_dst  in  AW  MEM stage destination
  wb_we  in  1  writeback enable
  wb_addr  in  AW  writeback index
  wb_data  in  DATA_W  writeback data
  ex_flush  in  1  squash decode instruction
  pc_write  out  1  PC and IF/ID enable; 0 = hold
  br_taken  out  1  branch condition true, combinational
  ex_valid, ex_mem_read  out  1  ID/EX register
  ex_dst  out  AW  ID/EX register
  ex_ctrl  out  CTRL_W  ID/EX register
  ex_rs_data, ex_rt_data, ex_pc_plus4  out  DATA_W  ID/EX register
  stall_count  out  16  saturating stall-cycle counter

Function
REQ-006 SHALL hold NREG x DATA_W registers; register 0 reads 0, writes to it ignored.
REQ-007 SHALL read rs/rt combinationally; same-cycle wb_we to same nonzero index SHALL bypass wb_data (write-through).
REQ-008 load_use SHALL be id_valid & ex_valid & ex_mem_read & ex_dst!=0 & ((id_rs_used & id_rs==ex_dst) | (id_rt_used & id_rt==ex_dst)).
REQ-009 br_hazard SHALL be id_valid & id_br_op!=0 & rs/rt match (same used-qualified rule) against ex_dst (ex_valid, ex_dst!=0), or against mem_dst when mem_valid & mem_mem_read & mem_dst!=0.
REQ-010 stall = load_use | br_hazard; pc_write = ~stall.
REQ-011 br_taken SHALL compare bypassed rs/rt as signed DATA_W: beq rs==rt; bne rs!=rt; blez rs<=0; bgtz rs>0; bgez rs>=0; bltz rs<0; none/reserved -> 0; forced 0 when ~id_valid or stall.
REQ-012 Each clock, ID/EX SHALL load: bubble (ex_valid=0, ex_mem_read=0, ex_ctrl=0, ex_dst=0) if ex_flush | stall | exc_req | ~id_valid; else all decode fields with ex_valid=1. Data fields of a bubble are don't-care but SHALL be 0.
REQ-013 Priority: ex_flush > exc_req > stall; exc_req with ex_flush SHALL be ignored.
REQ-014 exc_req & id_valid & ~ex_flush SHALL write id_pc_plus4-4 (mod 2^DATA_W) into EPC_REG at the edge; wins over wb_we to EPC_REG same cycle; does not stall.
REQ-015 stall_count SHALL increment once per cycle with stall=1 and ex_flush=0, saturating at 16'hFFFF.
REQ-016 Latency: decode inputs to ex_* outputs one clock; br_taken, pc_write zero clocks.

Reset
REQ-017 rst_n low SHALL asynchronously clear all registers, all ID/EX fields, and stall_count to 0; pc_write then depends only on inputs.
REQ-018 Reset asserted mid-stall SHALL leave ex_valid=0 and stall_count=0 at first edge after release.

Verification
REQ-019 Write r5=0x1234 via WB, same cycle decode rs=5 -> ex_rs_data=0x1234 next cycle; rs=0 -> 0.
REQ-020 EX holds lw to r8, decode add rs=8 -> pc_write=0, next ex_valid=0, stall_count=1; following cycle (load moved on) -> ex_valid=1.
REQ-021 beq rs=r1=7, rt=r2=7, no hazards -> br_taken=1; r2=8 -> 0; bltz rs=0x80000000 -> 1; blez rs=0 -> 1.
REQ-022 Branch on r3 with MEM holding lw r3 -> pc_write=0, br_taken=0 for that cycle; after MEM clears -> resolves.
REQ-023 exc_req with id_pc_plus4=0x00400010 and wb_we to r26=0xFF same cycle -> r26=0x0040000C, ex_valid=0; exc_req with ex_flush -> r26 unchanged.
REQ-024 Hold stall 70000 cycles -> stall_count=0xFFFF; rst_n pulse low mid-stall -> all outputs 0 asynchronously.
